// File: rtl/buzzer_round_controller_if.sv
// buzzer_round_controller_if: host control pulses and round status between host and controller
interface buzzer_round_controller_if #(
  parameter int SCORE_W = 4
);
  logic                   host_start;
  logic                   host_correct;
  logic                   host_wrong;
  logic [1:0]             state;
  logic                   winner_valid;
  logic [1:0]             winner_id;
  logic [3:0]             winner_code;
  logic [3:0]             lockout;
  logic                   timeout;
  logic [4*SCORE_W-1:0]   scores;
  modport master (
    output host_start, host_correct, host_wrong,
    input  state, winner_valid, winner_id, winner_code, lockout, timeout, scores
  );
  modport slave (
    input  host_start, host_correct, host_wrong,
    output state, winner_valid, winner_id, winner_code, lockout, timeout, scores
  );
endinterface

// File: rtl/buzzer_round_controller.sv
// buzzer_round_controller: 4-player buzzer round sequencer, first-press arbiter, answer timer and scorer
module buzzer_round_controller #(
  parameter int SYNC_STAGES   = 2,
  parameter int ANSWER_CYCLES = 1000,
  parameter int SCORE_W       = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [3:0]                 player_n,
  buzzer_round_controller_if.slave   bus
);
  localparam int TW = $clog2(ANSWER_CYCLES);
  typedef enum logic [1:0] {IDLE = 2'b00, ARMED = 2'b01, ANSWER = 2'b10} state_t;
  state_t             state_q, state_d;
  logic [3:0]         sync_q [SYNC_STAGES];
  logic [3:0]         prev_q, press, eligible, lock_q, lock_d, code_q, code_d;
  logic               valid_q, valid_d, to_q, to_d;
  logic [1:0]         id_q, id_d, first;
  logic [TW-1:0]      timer_q, timer_d;
  logic [SCORE_W-1:0] sc_q [4];
  logic [SCORE_W-1:0] sc_d [4];
  // button synchroniser chain (released = 1) and previous synced sample for press detection
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= 4'hf;
      prev_q <= 4'hf;
    end else begin
      sync_q[0] <= player_n;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  assign press    = prev_q & ~sync_q[SYNC_STAGES-1];
  assign eligible = press & ~lock_q;
  assign first    = eligible[0] ? 2'd0 : eligible[1] ? 2'd1 : eligible[2] ? 2'd2 : 2'd3;
  // round state, winner slot, lockouts, timer and scores
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      id_q    <= 2'd0;
      code_q  <= 4'd0;
      lock_q  <= 4'd0;
      to_q    <= 1'b0;
      timer_q <= '0;
      for (int p = 0; p < 4; p++) sc_q[p] <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      id_q    <= id_d;
      code_q  <= code_d;
      lock_q  <= lock_d;
      to_q    <= to_d;
      timer_q <= timer_d;
      for (int p = 0; p < 4; p++) sc_q[p] <= sc_d[p];
    end
  // next-state: grant lowest eligible player, then resolve correct / wrong / expiry
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    id_d    = id_q;
    lock_d  = lock_q;
    to_d    = 1'b0;
    timer_d = timer_q;
    for (int p = 0; p < 4; p++) sc_d[p] = sc_q[p];
    case (state_q)
      IDLE: if (bus.host_start) begin
        state_d = ARMED;
        lock_d  = 4'd0;
      end
      ARMED: if (|eligible) begin
        state_d = ANSWER;
        valid_d = 1'b1;
        id_d    = first;
        timer_d = TW'(ANSWER_CYCLES - 1);
      end
      ANSWER: begin
        timer_d = timer_q - TW'(1);
        if (bus.host_correct || bus.host_wrong || timer_q == '0) begin
          valid_d = 1'b0;
          id_d    = 2'd0;
          timer_d = '0;
          if (bus.host_correct) begin
            state_d     = IDLE;
            sc_d[id_q]  = (&sc_q[id_q]) ? sc_q[id_q] : sc_q[id_q] + SCORE_W'(1);
          end else begin
            lock_d[id_q] = 1'b1;
            to_d         = !bus.host_wrong;
            state_d      = (&lock_d) ? IDLE : ARMED;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    code_d = valid_d ? {2'b00, id_d} + 4'd1 : 4'd0;
  end
  assign bus.state        = state_q;
  assign bus.winner_valid = valid_q;
  assign bus.winner_id    = id_q;
  assign bus.winner_code  = code_q;
  assign bus.lockout      = lock_q;
  assign bus.timeout      = to_q;
  for (genvar g = 0; g < 4; g++) begin : g_sc
    assign bus.scores[g*SCORE_W +: SCORE_W] = sc_q[g];
  end
endmodule
